// File: rtl/wbm_desc_fetch_pkg.sv
// Shared DMA definitions for the descriptor fetch master: FSM encodings,
// failure codes, descriptor word offsets and field bit positions.
package wbm_desc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_RTY_WAIT = 2'd2,
        ST_FIN      = 2'd3
    } fetch_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_RETRY   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] WORD_NEXT = 2'd0;
    localparam logic [1:0] WORD_ADDR = 2'd1;
    localparam logic [1:0] WORD_CTL  = 2'd2;
    localparam logic [1:0] WORD_LEN  = 2'd3;
    localparam logic [1:0] LAST_BEAT = 2'd3;

    localparam int NEXT_LSB  = 3;
    localparam int ADDR_LSB  = 3;
    localparam int CTL_MSB   = 15;
    localparam int STATE_LSB = 24;
    localparam int LEN_MSB   = 23;

    localparam int DEF_TIMEOUT   = 255;
    localparam int DEF_MAX_RETRY = 3;
    localparam int DEF_RTY_WAIT  = 4;

    // Byte address of a descriptor beat; wraps modulo 2^32.
    function automatic logic [31:0] beat_adr(input logic [28:0] base, input logic [1:0] beat);
        return {base, 3'b000} + {28'd0, beat, 2'b00};
    endfunction

endpackage

// File: rtl/wbm_term_cnt.sv
// Loadable down-counter used for the bus timeout and the retry back-off;
// expired is high while the count sits at zero.
module wbm_term_cnt #(
    parameter int W = 8
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] cnt_r;

    // Count register: load wins over decrement, saturates at zero
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/wbm_desc_fetch.sv
// Wishbone master fetching one 4-word scatter/gather descriptor and
// reporting a single done/error result per fetch to the DMA controller.
module wbm_desc_fetch
    import wbm_desc_fetch_pkg::*;
#(
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int RTY_WAIT  = DEF_RTY_WAIT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        fetch_start,
    input  logic [31:3] fetch_adr,
    input  logic        fetch_abort,
    output logic        busy,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [31:3] desc_next,
    output logic [31:3] desc_addr,
    output logic [15:0] desc_ctl,
    output logic [7:0]  desc_state,
    output logic [23:0] desc_len,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int WAIT_W  = $clog2(RTY_WAIT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    fetch_state_e        state_r, state_s;
    logic [31:3]         base_r, base_s;
    logic [1:0]          beat_r, beat_s;
    logic [RETRY_W-1:0]  retry_r, retry_s;
    logic [1:0]          err_code_r, err_code_s;
    logic                cap_s, term_s;
    logic                tmo_dec_s, tmo_load_s, tmo_exp_s;
    logic                wait_dec_s, wait_load_s, wait_exp_s;
    logic                cyc_r, busy_r, done_r, ferr_r;
    logic [31:0]         adr_r;
    logic [31:3]         desc_next_r, desc_addr_r;
    logic [15:0]         desc_ctl_r;
    logic [7:0]          desc_state_r;
    logic [23:0]         desc_len_r;

    assign term_s      = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign tmo_dec_s   = (state_r == ST_REQ) && !term_s;
    assign tmo_load_s  = !tmo_dec_s;
    assign wait_dec_s  = (state_r == ST_RTY_WAIT);
    assign wait_load_s = !wait_dec_s;

    wbm_term_cnt #(.W(TMO_W)) u_tmo_cnt (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (tmo_load_s),
        .load_val (TMO_W'(TIMEOUT - 1)),
        .dec      (tmo_dec_s),
        .expired  (tmo_exp_s)
    );

    wbm_term_cnt #(.W(WAIT_W)) u_wait_cnt (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (wait_load_s),
        .load_val (WAIT_W'(RTY_WAIT - 1)),
        .dec      (wait_dec_s),
        .expired  (wait_exp_s)
    );

    // Next-state logic; termination priority is abort > err > rty > ack > timeout
    always_comb begin
        state_s    = state_r;
        base_s     = base_r;
        beat_s     = beat_r;
        retry_s    = retry_r;
        err_code_s = err_code_r;
        cap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fetch_start) begin
                    base_s     = fetch_adr;
                    beat_s     = 2'd0;
                    retry_s    = {RETRY_W{1'b0}};
                    err_code_s = ERR_NONE;
                    state_s    = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (fetch_abort) begin
                    state_s = ST_IDLE;
                end else if (wbm_err_i) begin
                    err_code_s = ERR_BUS;
                    state_s    = ST_FIN;
                end else if (wbm_rty_i) begin
                    if (retry_r == RETRY_MAX) begin
                        err_code_s = ERR_RETRY;
                        state_s    = ST_FIN;
                    end else begin
                        retry_s = retry_r + {{(RETRY_W-1){1'b0}}, 1'b1};
                        state_s = ST_RTY_WAIT;
                    end
                end else if (wbm_ack_i) begin
                    cap_s   = 1'b1;
                    beat_s  = beat_r + 2'd1;
                    retry_s = {RETRY_W{1'b0}};
                    if (beat_r == LAST_BEAT) begin
                        state_s = ST_FIN;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (tmo_exp_s) begin
                    err_code_s = ERR_TIMEOUT;
                    state_s    = ST_FIN;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RTY_WAIT: begin
                if (fetch_abort) begin
                    state_s = ST_IDLE;
                end else if (wait_exp_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_RTY_WAIT;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and bus-facing registers, all derived from the next state
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r    <= ST_IDLE;
            base_r     <= 29'd0;
            beat_r     <= 2'd0;
            retry_r    <= {RETRY_W{1'b0}};
            err_code_r <= ERR_NONE;
            cyc_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ferr_r     <= 1'b0;
            adr_r      <= 32'd0;
        end else begin
            state_r    <= state_s;
            base_r     <= base_s;
            beat_r     <= beat_s;
            retry_r    <= retry_s;
            err_code_r <= err_code_s;
            cyc_r      <= (state_s == ST_REQ);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_FIN) && (err_code_s == ERR_NONE);
            ferr_r     <= (state_s == ST_FIN) && (err_code_s != ERR_NONE);
            if (state_s == ST_REQ) begin
                adr_r <= beat_adr(base_s, beat_s);
            end else begin
                adr_r <= adr_r;
            end
        end
    end

    // Capture each acknowledged word into its descriptor field
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            desc_next_r  <= 29'd0;
            desc_addr_r  <= 29'd0;
            desc_ctl_r   <= 16'd0;
            desc_state_r <= 8'd0;
            desc_len_r   <= 24'd0;
        end else if (cap_s) begin
            case (beat_r)
                WORD_NEXT: desc_next_r <= wbm_dat_i[31:NEXT_LSB];
                WORD_ADDR: desc_addr_r <= wbm_dat_i[31:ADDR_LSB];
                WORD_CTL: begin
                    desc_ctl_r   <= wbm_dat_i[CTL_MSB:0];
                    desc_state_r <= wbm_dat_i[31:STATE_LSB];
                end
                WORD_LEN:  desc_len_r <= wbm_dat_i[LEN_MSB:0];
                default: begin
                    desc_next_r <= desc_next_r;
                end
            endcase
        end else begin
            desc_next_r <= desc_next_r;
        end
    end

    assign busy       = busy_r;
    assign fetch_done = done_r;
    assign fetch_err  = ferr_r;
    assign err_code   = err_code_r;
    assign desc_next  = desc_next_r;
    assign desc_addr  = desc_addr_r;
    assign desc_ctl   = desc_ctl_r;
    assign desc_state = desc_state_r;
    assign desc_len   = desc_len_r;
    assign wbm_cyc_o  = cyc_r;
    assign wbm_stb_o  = cyc_r;
    assign wbm_cab_o  = cyc_r;
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = 4'hF;
    assign wbm_adr_o  = adr_r;

endmodule

// File: tb/tb_wbm_desc_fetch.sv
// Self-checking bench for wbm_desc_fetch: table of fetch scenarios against a
// scripted zero-wait slave, plus abort and mid-burst reset sequences.
module tb_wbm_desc_fetch;

    logic        wb_clk_i, wb_rst_i, fetch_start, fetch_abort;
    logic [31:3] fetch_adr;
    logic        busy, fetch_done, fetch_err;
    logic [1:0]  err_code;
    logic [31:3] desc_next, desc_addr;
    logic [15:0] desc_ctl;
    logic [7:0]  desc_state;
    logic [23:0] desc_len;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

    typedef struct packed {
        logic [28:0]      base;
        logic [3:0][31:0] w;
        int               rty_beat;
        int               rty_times;
        int               err_beat;
        bit               all_terms;
        bit               mute;
        bit               exp_done;
        logic [1:0]       exp_code;
        int               exp_cyc;
        logic [28:0]      e_next;
        logic [28:0]      e_addr;
        logic [15:0]      e_ctl;
        logic [7:0]       e_state;
        logic [23:0]      e_len;
    } vec_t;

    typedef struct packed {
        logic [31:0] act;
        logic [31:0] exp;
        logic [5:0]  ctl;
    } obs_t;

    vec_t vecs [8];
    vec_t sb [$];
    obs_t obs [$];
    vec_t cur;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   done_before, err_before;

    wbm_desc_fetch dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .fetch_start(fetch_start), .fetch_adr(fetch_adr), .fetch_abort(fetch_abort),
        .busy(busy), .fetch_done(fetch_done), .fetch_err(fetch_err), .err_code(err_code),
        .desc_next(desc_next), .desc_addr(desc_addr), .desc_ctl(desc_ctl),
        .desc_state(desc_state), .desc_len(desc_len),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_cab_o(wbm_cab_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .wbm_rty_i(wbm_rty_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (fetch_done) done_cnt <= done_cnt + 1;
        if (fetch_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [28:0] base, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3, input int rb, input int rt,
                                input int eb, input bit at, input bit mute, input bit done,
                                input logic [1:0] code, input int cyc);
        vec_t v;
        v.base = base; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.rty_beat = rb; v.rty_times = rt; v.err_beat = eb; v.all_terms = at; v.mute = mute;
        v.exp_done = done; v.exp_code = code; v.exp_cyc = cyc;
        v.e_next = w0[31:3]; v.e_addr = w1[31:3]; v.e_ctl = w2[15:0];
        v.e_state = w2[31:24]; v.e_len = w3[23:0];
        return v;
    endfunction

    // Scripted zero-wait slave; records each request with its expected address
    int s_beat, s_rty_seen;
    initial begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = 32'd0;
        s_beat = 0; s_rty_seen = 0;
        forever begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_rty_i = 1'b0; wbm_dat_i = 32'hDEAD_BEEF;
            if (wb_rst_i || !busy) begin
                s_beat = 0; s_rty_seen = 0;
            end else if (wbm_cyc_o && wbm_stb_o) begin
                obs.push_back('{act: wbm_adr_o,
                                exp: {cur.base, 3'b000} + 32'(s_beat) * 32'd4,
                                ctl: {wbm_cab_o, wbm_we_o, wbm_sel_o}});
                if (!cur.mute) begin
                    if (s_beat == cur.err_beat) begin
                        wbm_err_i = 1'b1;
                        wbm_ack_i = cur.all_terms;
                        wbm_rty_i = cur.all_terms;
                    end else if (s_beat == cur.rty_beat && s_rty_seen < cur.rty_times) begin
                        wbm_rty_i = 1'b1;
                        s_rty_seen++;
                    end else begin
                        wbm_ack_i = 1'b1;
                        wbm_dat_i = cur.w[s_beat[1:0]];
                        s_beat++;
                    end
                end
            end
        end
    end

    task automatic start_fetch(input vec_t v, input bit push);
        cur = v;
        fetch_adr = v.base;
        fetch_start = 1'b1;
        if (push) sb.push_back(v);
    endtask

    task automatic wait_result();
        vec_t e;
        obs_t o;
        bit   seen;
        int   n;
        seen = 1'b0; n = 1;
        @(negedge wb_clk_i);
        fetch_start = 1'b0;
        while (!seen && n <= 400) begin
            if (n == 1) chk("cyc_stb_busy_c1", 32'({wbm_cyc_o, wbm_stb_o, busy}), 32'd7);
            if (fetch_done || fetch_err) seen = 1'b1;
            else begin
                @(negedge wb_clk_i);
                n++;
            end
        end
        chk("result_seen", 32'(seen), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result_kind", 32'({fetch_done, fetch_err}), e.exp_done ? 32'd2 : 32'd1);
            chk("err_code", 32'(err_code), 32'(e.exp_code));
            chk("result_cycle", 32'(n), 32'(e.exp_cyc));
            chk("fin_cyc_busy", 32'({wbm_cyc_o, busy}), 32'd1);
            if (e.exp_done) begin
                chk("desc_next", 32'(desc_next), 32'(e.e_next));
                chk("desc_addr", 32'(desc_addr), 32'(e.e_addr));
                chk("desc_ctl", 32'(desc_ctl), 32'(e.e_ctl));
                chk("desc_state", 32'(desc_state), 32'(e.e_state));
                chk("desc_len", 32'(desc_len), 32'(e.e_len));
            end
            while (obs.size() != 0) begin
                o = obs.pop_front();
                chk("beat_adr", o.act, o.exp);
                chk("bus_ctl", 32'(o.ctl), 32'h2F);
            end
            @(negedge wb_clk_i);
            chk("post_idle", 32'({fetch_done, fetch_err, busy}), 32'd0);
            chk("err_code_hold", 32'(err_code), 32'(e.exp_code));
        end else begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end
    endtask

    initial begin
        wb_rst_i = 1'b1; fetch_start = 1'b0; fetch_abort = 1'b0; fetch_adr = 29'd0;
        vecs[0] = mk(29'h0200_0000, 32'h2000_0008, 32'h3000_0000, 32'hAB00_1234, 32'h0000_0200,
                     -1, 0, -1, 1'b0, 1'b0, 1'b1, 2'b00, 5);
        vecs[0].e_next = 29'h0400_0001; vecs[0].e_addr = 29'h0600_0000;
        vecs[0].e_ctl = 16'h1234; vecs[0].e_state = 8'hAB; vecs[0].e_len = 24'h000200;
        vecs[1] = mk(29'h0200_0000, 32'h2000_0008, 32'h3000_0000, 32'hAB00_1234, 32'h0000_0200,
                     2, 1, -1, 1'b0, 1'b0, 1'b1, 2'b00, 10);
        vecs[2] = mk(29'h0246_8ACE, 32'h1, 32'h2, 32'h3, 32'h4, 0, 4, -1, 1'b0, 1'b0, 1'b0, 2'b10, 17);
        vecs[3] = mk(29'h0200_0000, 32'h1, 32'h2, 32'h3, 32'h4, -1, 0, 1, 1'b0, 1'b0, 1'b0, 2'b01, 3);
        vecs[4] = mk(29'h0300_0000, 32'h1, 32'h2, 32'h3, 32'h4, -1, 0, -1, 1'b0, 1'b1, 1'b0, 2'b11, 256);
        vecs[5] = mk(29'h1FFF_FFFF, 32'h1111_1118, 32'h2222_2220, 32'h5A00_BEEF, 32'h00FF_FFFF,
                     -1, 0, -1, 1'b0, 1'b0, 1'b1, 2'b00, 5);
        vecs[6] = mk(29'h0000_0001, 32'hFFFF_FFF8, 32'h0000_0008, 32'h0100_8001, 32'h0012_3456,
                     3, 3, -1, 1'b0, 1'b0, 1'b1, 2'b00, 20);
        vecs[7] = mk(29'h0200_0000, 32'h1, 32'h2, 32'h3, 32'h4, -1, 0, 0, 1'b1, 1'b0, 1'b0, 2'b01, 2);

        repeat (2) @(negedge wb_clk_i);
        chk("rst_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_we_o, busy, fetch_done, fetch_err}), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'hF);
        chk("rst_desc", 32'(desc_next) | 32'(desc_addr) | 32'(desc_ctl) | 32'(desc_state)
                        | 32'(desc_len) | 32'(err_code), 32'd0);
        wb_rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            start_fetch(vecs[i], 1'b1);
            wait_result();
        end

        // Abort during beat 2, then restart one cycle later
        done_before = done_cnt; err_before = err_cnt;
        @(negedge wb_clk_i);
        start_fetch(vecs[0], 1'b0);
        @(negedge wb_clk_i); fetch_start = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("abort_beat2_adr", wbm_adr_o, 32'h1000_0008);
        fetch_abort = 1'b1;
        @(negedge wb_clk_i);
        fetch_abort = 1'b0;
        chk("abort_drop", 32'({wbm_cyc_o, wbm_stb_o, busy, fetch_done, fetch_err}), 32'd0);
        start_fetch(vecs[5], 1'b1);
        wait_result();
        chk("abort_done_pulses", 32'(done_cnt - done_before), 32'd1);
        chk("abort_err_pulses", 32'(err_cnt - err_before), 32'd0);

        // Reset asserted mid-burst clears everything without waiting for an edge
        @(negedge wb_clk_i);
        start_fetch(vecs[0], 1'b0);
        @(negedge wb_clk_i); fetch_start = 1'b0;
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_cab_o, busy, fetch_done, fetch_err}), 32'd0);
        chk("mid_rst_adr", wbm_adr_o, 32'd0);
        chk("mid_rst_sel", 32'(wbm_sel_o), 32'hF);
        chk("mid_rst_desc", 32'(desc_next) | 32'(desc_addr) | 32'(desc_ctl) | 32'(desc_state)
                            | 32'(desc_len) | 32'(err_code), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;

        @(negedge wb_clk_i);
        start_fetch(vecs[0], 1'b1);
        wait_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbm_desc_fetch.md
# wbm_desc_fetch

Wishbone master that fetches one 4-word scatter/gather descriptor from system memory on request and presents the decoded fields to the DMA controller. Sits between the DMA control state machine and the shared Wishbone master port. It is the initiator counterpart of the DMA register slave: it reads the `ndar`/`next_desc` pointers and `sg_*` fields that the slave only reports. It handles retry, error and timeout termination so the controller sees a single done/error result per fetch.

## Interface
- `TIMEOUT`, 255: cycles with `stb` high and no `ack`/`err`/`rty` before the fetch aborts.
- `MAX_RETRY`, 3: `rty` terminations tolerated per beat before the fetch aborts.
- `RTY_WAIT`, 4: idle cycles, with `cyc` and `stb` low, between an `rty` and re-issue of the same beat.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `fetch_start` in 1: one-cycle request; sampled only in IDLE.
- `fetch_adr` in [31:3]: descriptor base address; 8-byte aligned.
- `fetch_abort` in 1: terminate the fetch at once. Used when the controller drops `enable`.
- `busy` out 1: fetch in progress.
- `fetch_done` out 1: one-cycle pulse; all four words were captured.
- `fetch_err` out 1: one-cycle pulse; the fetch failed.
- `err_code` out [1:0]: cause of failure. 01 = bus `err`, 10 = retry limit, 11 = timeout. Held until the next `fetch_start`.
- `desc_next` out [31:3]: next descriptor pointer.
- `desc_addr` out [31:3]: buffer address.
- `desc_ctl` out [15:0]: descriptor control word.
- `desc_state` out [7:0]: descriptor state byte.
- `desc_len` out [23:0]: byte count.
- `wbm_cyc_o`, `wbm_stb_o` out 1: Wishbone cycle and strobe.
- `wbm_we_o` out 1: constant 0.
- `wbm_cab_o` out 1: high whenever `cyc` is high.
- `wbm_sel_o` out [3:0]: constant 4'hF.
- `wbm_adr_o` out [31:0]: byte address of the current beat.
- `wbm_dat_i` in [31:0]: read data.
- `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i` in 1: Wishbone cycle terminations.

## Operation
- Descriptor layout in memory:
  - word0[31:3] → `desc_next`
  - word1[31:3] → `desc_addr`
  - word2[15:0] → `desc_ctl`
  - word2[31:24] → `desc_state`
  - word3[23:0] → `desc_len`
- FSM states: IDLE, REQ, RTY_WAIT, FIN.
- IDLE:
  - `fetch_start` latches the base address, clears `beat`, the retry counter and `err_code`.
  - Next state is REQ.
- REQ: `cyc` and `stb` high; `wbm_adr_o` = {base, 3'b000} + 4·`beat`.
- On `ack` in REQ:
  - Capture `wbm_dat_i` into the field for the current beat.
  - Increment `beat` and reset the retry and timeout counters.
  - If `beat` was 3, go to FIN; otherwise stay in REQ with the next address.
- On `err` in REQ: drop `cyc`, set `err_code`=01, go to FIN.
- On `rty` in REQ:
  - If the retry count equals `MAX_RETRY`: `err_code`=10, go to FIN.
  - Otherwise increment the retry count and go to RTY_WAIT.
- Timeout: `TIMEOUT` consecutive REQ cycles with no termination → `err_code`=11, go to FIN.
- RTY_WAIT: `cyc` low; after `RTY_WAIT` cycles return to REQ at the same beat.
- FIN:
  - Pulse `fetch_done` if `err_code`==0, otherwise pulse `fetch_err`.
  - Return to IDLE.
- Simultaneous `ack`/`err`/`rty`: priority is `err` > `rty` > `ack`.
- `fetch_abort`, in any non-IDLE state:
  - Go to IDLE on the next edge; `cyc`/`stb` fall that edge.
  - No done or error pulse; partially captured fields are undefined.
- `fetch_start` outside IDLE is ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Timing
- Reset values: all outputs 0 except `wbm_sel_o`=4'hF. FSM goes to IDLE and counters clear.
- Reset mid-fetch drops `cyc` asynchronously.
- With `fetch_start` at edge 0:
  - `cyc`/`stb` are high from cycle 1.
  - With a zero-wait slave, `ack` arrives in cycles 1–4.
  - `fetch_done` is high in cycle 5; `busy` is low in cycle 6.
  - Minimum latency from start to done: 5 cycles.
- `busy` is high from the cycle after `fetch_start` through the FIN cycle.
- `stb` stays high across beats; the address advances on the same edge that registers `ack`.
- Descriptor fields are valid from the `fetch_done` cycle until the next `fetch_start`.
- All outputs are registered.

## Structure
- Shared DMA package holds:
  - FSM state encodings
  - `err_code` constants
  - descriptor word offsets and field bit positions
- Natural sub-module: `wbm_term_cnt`, the timeout/retry-wait down-counter with load and expire. It is instantiated twice.

## Test plan
- Zero-wait slave, base 0x1000_0000, words 0x2000_0008 / 0x3000_0000 / 0xAB00_1234 / 0x0000_0200:
  - addresses 0x1000_0000…0x1000_000C
  - `fetch_done` in cycle 5
  - `desc_next`=0x2000_0008>>3, `desc_addr`=0x3000_0000>>3, `desc_ctl`=0x1234, `desc_state`=0xAB, `desc_len`=0x200
- `rty` once on beat 2: `cyc` low for 4 cycles, beat 2 re-issued at 0x1000_0008, done in cycle 10.
- `rty` 4 times on beat 0: `fetch_err` with `err_code`=10; no `fetch_done`.
- `err` on beat 1: `cyc` low next cycle, `fetch_err` with `err_code`=01.
- Slave never responds: `fetch_err` with `err_code`=11 after 255 `stb` cycles.
- `fetch_abort` during beat 2, then `fetch_start` one cycle later: no pulse from the aborted fetch; the new fetch completes normally. Also cover assertion of `wb_rst_i` mid-burst: all outputs are 0 immediately.
